lcd_controller: RTL and testbench



---
 rtl/lcd_controller_pkg.sv | 25 ++
 rtl/lcd_controller_byte_sender.sv | 78 +++++++
 rtl/lcd_controller.sv | 159 +++++++++++++++
 tb/tb_lcd_controller.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/lcd_controller_pkg.sv
// Shared definitions for the HD44780 4-bit LCD write path.
// Holds the FSM encodings, the init/config tables and the slow-command rule.
package lcd_controller_pkg;

  typedef enum logic [2:0] {
    ST_INIT_WAIT, ST_INIT_NIB, ST_INIT_DLY, ST_CFG, ST_IDLE, ST_BYTE, ST_POST_WAIT
  } state_t;

  typedef enum logic [2:0] {
    SP_IDLE, SP_SETUP, SP_PULSE, SP_HOLD, SP_GAP
  } phase_t;

  // Element [0] is sent first.
  localparam logic [3:0][3:0] INIT_NIBS = {4'h2, 4'h3, 4'h3, 4'h3};
  localparam logic [3:0][7:0] CFG_CMDS  = {8'h01, 8'h0C, 8'h06, 8'h28};

  localparam logic [7:0] OP_CLEAR = 8'h01;
  localparam logic [7:0] OP_HOME  = 8'h02;

  // Clear and home need the long post-wait; every other byte uses the short one.
  function automatic logic is_slow_cmd(input logic [7:0] b, input logic rs);
    return !rs && (b == OP_CLEAR || b == OP_HOME);
  endfunction

endpackage

// File: rtl/lcd_controller_byte_sender.sv
// Drives E/RS/data for one byte (two nibbles) or a single init nibble.
// Owns the setup, E-pulse, hold and inter-nibble gap timing.
module lcd_byte_sender
  import lcd_controller_pkg::*;
#(
  parameter int T_SETUP  = 2,
  parameter int T_EPULSE = 12,
  parameter int T_GAP    = 50
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] din,
  input  logic       rs_in,
  input  logic       nibble_only,
  output logic       done,
  output logic       busy,
  output logic       e,
  output logic       rs,
  output logic [3:0] data
);

  if (T_SETUP < 1 || T_SETUP > 256 || T_EPULSE < 1 || T_EPULSE > 256 ||
      T_GAP < 1 || T_GAP > 256) begin : g_chk
    $error("lcd_byte_sender: nibble timing does not fit the 8-bit counter");
  end

  phase_t     phase, phase_n;
  logic [7:0] tcnt, tcnt_n;
  logic [3:0] lo_nib;
  logic       second;

  always_ff @(posedge clk) begin
    if (rst) begin
      phase  <= SP_IDLE;
      tcnt   <= '0;
      data   <= '0;
      rs     <= 1'b0;
      lo_nib <= '0;
      second <= 1'b0;
    end else begin
      phase <= phase_n;
      tcnt  <= tcnt_n;
      if (start && phase == SP_IDLE) begin
        rs     <= rs_in;
        data   <= nibble_only ? din[3:0] : din[7:4];
        lo_nib <= din[3:0];
        second <= nibble_only;
      end else if (phase == SP_GAP && tcnt == '0) begin
        data   <= lo_nib;
        second <= 1'b1;
      end
    end
  end

  always_comb begin
    phase_n = phase;
    tcnt_n  = (tcnt != '0) ? tcnt - 8'd1 : tcnt;
    case (phase)
      SP_IDLE:  if (start) begin phase_n = SP_SETUP; tcnt_n = 8'(T_SETUP - 1); end
      SP_SETUP: if (tcnt == '0) begin phase_n = SP_PULSE; tcnt_n = 8'(T_EPULSE - 1); end
      SP_PULSE: if (tcnt == '0) phase_n = SP_HOLD;
      SP_HOLD: begin
        if (second) phase_n = SP_IDLE;
        else begin phase_n = SP_GAP; tcnt_n = 8'(T_GAP - 1); end
      end
      SP_GAP:   if (tcnt == '0) begin phase_n = SP_SETUP; tcnt_n = 8'(T_SETUP - 1); end
      default:  phase_n = SP_IDLE;
    endcase
  end

  always_comb begin
    e    = (phase == SP_PULSE);
    busy = (phase != SP_IDLE);
    done = (phase == SP_HOLD) && second;
  end

endmodule

// File: rtl/lcd_controller.sv
// HD44780 4-bit LCD controller: power-on init, configuration, then one byte per
// accepted CPU write strobe. Long waits share one down-counter.
module lcd_controller
  import lcd_controller_pkg::*;
#(
  parameter int CNT_W     = 20,
  parameter int T_POWERON = 750000,
  parameter int T_4100US  = 205000,
  parameter int T_100US   = 5000,
  parameter int T_40US    = 2000,
  parameter int T_1640US  = 82000,
  parameter int T_SETUP   = 2,
  parameter int T_EPULSE  = 12,
  parameter int T_GAP     = 50
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic [7:0] iLCD_Data,
  input  logic       iLCD_RegisterSelect,
  input  logic       iLCD_Write,
  output logic       oLCD_Ready,
  output logic       oLCD_Enabled,
  output logic       oLCD_RegisterSelect,
  output logic       oLCD_ReadWrite,
  output logic       oLCD_StrataFlashControl,
  output logic [3:0] oLCD_Data
);

  localparam longint CNT_MAX = longint'(1) << CNT_W;

  if (T_POWERON < 2 || longint'(T_POWERON) > CNT_MAX || longint'(T_4100US) > CNT_MAX ||
      longint'(T_100US) > CNT_MAX || longint'(T_40US) > CNT_MAX ||
      longint'(T_1640US) > CNT_MAX || T_4100US < 1 || T_100US < 1 || T_40US < 1 ||
      T_1640US < 1) begin : g_chk
    $error("lcd_controller: delay parameter does not fit CNT_W");
  end

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [2:0]       init_idx, init_idx_n, cfg_idx, cfg_idx_n;
  logic             fresh;
  logic [7:0]       byte_q;
  logic             rs_q;
  logic             snd_start, snd_nib_only, snd_rs, snd_done, snd_busy;
  logic [7:0]       snd_din;

  function automatic logic [CNT_W-1:0] post_dly(input logic [7:0] b, input logic rs);
    return is_slow_cmd(b, rs) ? CNT_W'(T_1640US - 1) : CNT_W'(T_40US - 1);
  endfunction

  function automatic logic [CNT_W-1:0] init_dly(input logic [1:0] idx);
    case (idx)
      2'd0:    return CNT_W'(T_4100US - 1);
      2'd1:    return CNT_W'(T_100US - 1);
      default: return CNT_W'(T_40US - 1);
    endcase
  endfunction

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state    <= ST_INIT_WAIT;
      cnt      <= '0;
      init_idx <= '0;
      cfg_idx  <= '0;
      fresh    <= 1'b1;
      byte_q   <= '0;
      rs_q     <= 1'b0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      init_idx <= init_idx_n;
      cfg_idx  <= cfg_idx_n;
      fresh    <= 1'b0;
      if (state == ST_IDLE && iLCD_Write) begin
        byte_q <= iLCD_Data;
        rs_q   <= iLCD_RegisterSelect;
      end
    end
  end

  always_comb begin
    state_n    = state;
    cnt_n      = (cnt != '0) ? cnt - 1'b1 : cnt;
    init_idx_n = init_idx;
    cfg_idx_n  = cfg_idx;
    case (state)
      // Counter is zero out of reset, so the power-on wait is loaded on its first cycle.
      ST_INIT_WAIT: begin
        if (fresh) cnt_n = CNT_W'(T_POWERON - 2);
        else if (cnt == '0) state_n = ST_INIT_NIB;
      end
      ST_INIT_NIB: if (snd_done) begin
        state_n    = ST_INIT_DLY;
        cnt_n      = init_dly(init_idx[1:0]);
        init_idx_n = init_idx + 3'd1;
      end
      ST_INIT_DLY: if (cnt == '0) state_n = (init_idx == 3'd4) ? ST_CFG : ST_INIT_NIB;
      ST_CFG: if (snd_done) begin
        state_n   = ST_POST_WAIT;
        cnt_n     = post_dly(CFG_CMDS[cfg_idx[1:0]], 1'b0);
        cfg_idx_n = cfg_idx + 3'd1;
      end
      ST_IDLE: if (iLCD_Write) state_n = ST_BYTE;
      ST_BYTE: if (snd_done) begin
        state_n = ST_POST_WAIT;
        cnt_n   = post_dly(byte_q, rs_q);
      end
      ST_POST_WAIT: if (cnt == '0) state_n = (cfg_idx == 3'd4) ? ST_IDLE : ST_CFG;
      default: state_n = ST_INIT_WAIT;
    endcase
  end

  always_comb begin
    oLCD_Ready   = (state == ST_IDLE);
    snd_start    = 1'b0;
    snd_din      = '0;
    snd_rs       = 1'b0;
    snd_nib_only = 1'b0;
    case (state)
      ST_IDLE: begin
        snd_start = iLCD_Write;
        snd_din   = iLCD_Data;
        snd_rs    = iLCD_RegisterSelect;
      end
      ST_INIT_NIB: begin
        snd_start    = !snd_busy;
        snd_din      = {4'h0, INIT_NIBS[init_idx[1:0]]};
        snd_nib_only = 1'b1;
      end
      ST_CFG: begin
        snd_start = !snd_busy;
        snd_din   = CFG_CMDS[cfg_idx[1:0]];
      end
      default: ;
    endcase
  end

  assign oLCD_ReadWrite          = 1'b0;
  assign oLCD_StrataFlashControl = 1'b1;

  lcd_byte_sender #(
    .T_SETUP (T_SETUP),
    .T_EPULSE(T_EPULSE),
    .T_GAP   (T_GAP)
  ) u_sender (
    .clk        (Clock),
    .rst        (Reset),
    .start      (snd_start),
    .din        (snd_din),
    .rs_in      (snd_rs),
    .nibble_only(snd_nib_only),
    .done       (snd_done),
    .busy       (snd_busy),
    .e          (oLCD_Enabled),
    .rs         (oLCD_RegisterSelect),
    .data       (oLCD_Data)
  );

endmodule

// File: tb/tb_lcd_controller.sv
// Scoreboard bench for lcd_controller with scaled timing: expected E pulses are
// queued at stimulus time and checked by an independent pulse monitor.
module tb_lcd_controller;

  localparam int T_POWERON = 100, T_4100US = 40, T_100US = 10, T_40US = 8;
  localparam int T_1640US = 30, T_SETUP = 2, T_EPULSE = 4, T_GAP = 5;
  localparam int NIB = T_SETUP + T_EPULSE + 1;

  logic       Clock = 1'b0;
  logic       Reset = 1'b1;
  logic [7:0] iLCD_Data = '0;
  logic       iLCD_RegisterSelect = 1'b0;
  logic       iLCD_Write = 1'b0;
  logic       oLCD_Ready, oLCD_Enabled, oLCD_RegisterSelect, oLCD_ReadWrite;
  logic       oLCD_StrataFlashControl;
  logic [3:0] oLCD_Data;

  lcd_controller #(
    .CNT_W(20), .T_POWERON(T_POWERON), .T_4100US(T_4100US), .T_100US(T_100US),
    .T_40US(T_40US), .T_1640US(T_1640US), .T_SETUP(T_SETUP), .T_EPULSE(T_EPULSE),
    .T_GAP(T_GAP)
  ) dut (
    .Clock(Clock), .Reset(Reset), .iLCD_Data(iLCD_Data),
    .iLCD_RegisterSelect(iLCD_RegisterSelect), .iLCD_Write(iLCD_Write),
    .oLCD_Ready(oLCD_Ready), .oLCD_Enabled(oLCD_Enabled),
    .oLCD_RegisterSelect(oLCD_RegisterSelect), .oLCD_ReadWrite(oLCD_ReadWrite),
    .oLCD_StrataFlashControl(oLCD_StrataFlashControl), .oLCD_Data(oLCD_Data)
  );

  always #5 Clock = ~Clock;

  typedef struct {
    logic       rs;
    logic [3:0] nib;
    int         gap;  // E-low clocks before this pulse, 0 = not checked
  } exp_t;

  exp_t q[$];
  int   tests = 0;
  int   fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  task automatic push_nib(input logic rs, input logic [3:0] nib, input int gap);
    exp_t x;
    x.rs = rs; x.nib = nib; x.gap = gap;
    q.push_back(x);
  endtask

  task automatic push_byte(input logic [7:0] b, input logic rs);
    push_nib(rs, b[7:4], 0);
    push_nib(rs, b[3:0], 1 + T_GAP + T_SETUP);
  endtask

  task automatic push_init();
    logic [3:0] nibs [4] = '{4'h3, 4'h3, 4'h3, 4'h2};
    logic [7:0] cmds [4] = '{8'h28, 8'h06, 8'h0C, 8'h01};
    foreach (nibs[i]) push_nib(1'b0, nibs[i], 0);
    foreach (cmds[i]) push_byte(cmds[i], 1'b0);
  endtask

  function automatic int exp_lat(input logic [7:0] b, input logic rs);
    int post;
    post = (!rs && (b == 8'h01 || b == 8'h02)) ? T_1640US : T_40US;
    return 2 * NIB + T_GAP + post;
  endfunction

  // Pulse monitor: pops one expectation per E rising edge.
  int   hi_w = 0, lo_w = 0;
  logic e_prev = 1'b0;
  always @(negedge Clock) begin
    exp_t x;
    if (Reset) begin
      e_prev = 1'b0; hi_w = 0; lo_w = 0;
    end else begin
      if (oLCD_Enabled && !e_prev) begin
        if (q.size() == 0) chk("unexpected_pulse", {27'd0, oLCD_RegisterSelect, oLCD_Data}, 32'hffff);
        else begin
          x = q.pop_front();
          chk("pulse_rs_data", {oLCD_RegisterSelect, oLCD_Data}, {x.rs, x.nib});
          if (x.gap != 0) chk("nibble_gap", lo_w, x.gap);
        end
        chk("rw_sfce", {oLCD_ReadWrite, oLCD_StrataFlashControl}, 2'b01);
        chk("ready_low_in_pulse", oLCD_Ready, 1'b0);
        hi_w = 1;
      end else if (oLCD_Enabled) begin
        hi_w++;
      end else if (e_prev) begin
        chk("e_width", hi_w, T_EPULSE);
        lo_w = 1;
      end else begin
        lo_w++;
      end
      e_prev = oLCD_Enabled;
    end
  end

  task automatic wait_ready(input int budget, input string name);
    int n = 0;
    while (!oLCD_Ready && n < budget) begin
      @(negedge Clock);
      n++;
    end
    chk(name, oLCD_Ready, 1'b1);
  endtask

  // Issue one write and check ready-low duration; glitch>0 strobes 0x4F while busy.
  task automatic write_byte(input logic [7:0] b, input logic rs, input int glitch);
    int n;
    wait_ready(500, "ready_before_write");
    iLCD_Data = b; iLCD_RegisterSelect = rs; iLCD_Write = 1'b1;
    push_byte(b, rs);
    @(posedge Clock);
    #1;
    iLCD_Write = 1'b0;
    iLCD_Data = 8'($urandom);
    iLCD_RegisterSelect = 1'($urandom);
    @(negedge Clock);
    chk("ready_fall", oLCD_Ready, 1'b0);
    n = 1;
    while (!oLCD_Ready && n < 500) begin
      if (n == glitch) begin
        iLCD_Write = 1'b1; iLCD_Data = 8'h4F; iLCD_RegisterSelect = 1'b1;
      end else iLCD_Write = 1'b0;
      @(negedge Clock);
      n++;
    end
    iLCD_Write = 1'b0;
    chk("ready_latency", n - 1, exp_lat(b, rs));
    chk("pulses_pending", q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] hola [4] = '{8'h48, 8'h4F, 8'h4C, 8'h41};
    logic [7:0] b;
    logic       rs;
    int         n;

    repeat (3) @(negedge Clock);
    chk("rst_ready", oLCD_Ready, 1'b0);
    chk("rst_e", oLCD_Enabled, 1'b0);
    chk("rst_rs", oLCD_RegisterSelect, 1'b0);
    chk("rst_data", oLCD_Data, 4'h0);
    chk("rst_rw_sfce", {oLCD_ReadWrite, oLCD_StrataFlashControl}, 2'b01);

    // Power-on init and configuration
    push_init();
    Reset = 1'b0;
    wait_ready(3000, "init_ready");
    chk("init_pulses_left", q.size(), 0);

    write_byte(8'h48, 1'b1, 0);
    write_byte(8'h01, 1'b0, 0);
    write_byte(8'h48, 1'b1, 10);

    // Reset during the high-nibble E pulse restarts the whole init
    iLCD_Data = 8'h48; iLCD_RegisterSelect = 1'b1; iLCD_Write = 1'b1;
    push_byte(8'h48, 1'b1);
    @(posedge Clock);
    #1;
    iLCD_Write = 1'b0;
    n = 0;
    while (!oLCD_Enabled && n < 100) begin
      @(negedge Clock);
      n++;
    end
    chk("reset_e_seen", oLCD_Enabled, 1'b1);
    Reset = 1'b1;
    @(negedge Clock);
    chk("reset_e_drop", oLCD_Enabled, 1'b0);
    chk("reset_ready", oLCD_Ready, 1'b0);
    q.delete();
    push_init();
    @(negedge Clock);
    Reset = 1'b0;
    wait_ready(3000, "reinit_ready");
    chk("reinit_pulses_left", q.size(), 0);

    foreach (hola[i]) write_byte(hola[i], 1'b1, 0);

    repeat (20) begin
      b  = 8'($urandom);
      rs = 1'($urandom);
      if ($urandom_range(3) == 0) begin
        b  = 8'($urandom_range(2, 1));
        rs = 1'b0;
      end
      repeat ($urandom_range(3)) @(negedge Clock);
      write_byte(b, rs, 0);
    end

    repeat (5) @(negedge Clock);
    chk("final_queue_empty", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
